// File: rtl/tri_decoder.sv
// Triangular-number decoder: peels 1,2,3,... off w_in until the
// next term no longer fits; n = terms removed, rem = leftover.
// Ports: clk, reset (sync, active-high), start, w_in ->
//        busy, done (1-cycle pulse), n, rem.
module tri_decoder #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] w_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] n,
  output logic [WIDTH-1:0] rem
);

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] r;
  logic [CNT_W-1:0] b;
  logic [CNT_W-1:0] cnt;
  logic             fits;

  // b is zero-extended, so the compare is unsigned and r >= b
  // guarantees r - b never underflows.
  assign fits = (r >= WIDTH'(b));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SUB;
      SUB:     if (!fits) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r   <= '0;
      b   <= '0;
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            r   <= w_in;
            b   <= CNT_W'(1);
            cnt <= '0;
          end
        end
        SUB: begin
          if (fits) begin
            r   <= r - WIDTH'(b);
            b   <= b + CNT_W'(1);
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  assign rem = r;
  assign n   = cnt;

endmodule

// File: tb/tb_tri_decoder.sv
// Self-checking bench for tri_decoder: arithmetic reference model
// checked every cycle, plus directed literal expectations.
module tb_tri_decoder;

  localparam int WIDTH = 6;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] w_in = '0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] rem;

  int total = 0;
  int bad = 0;

  tri_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .w_in(w_in),
    .busy(busy), .done(done), .n(n), .rem(rem)
  );

  always #5 clk = ~clk;

  function automatic int tri_sum(input int k);
    return k * (k + 1) / 2;
  endfunction

  function automatic int tri_n(input int w);
    int k = 0;
    while (tri_sum(k + 1) <= w) k++;
    return k;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: cycle c after acceptance has c terms removed,
  // capped at the final n; the cycle with c = n+1 is the done cycle.
  bit m_act = 0;
  int m_c = 0;
  int m_w = 0;
  int m_nf = 0;
  int m_hold_n = 0;
  int m_hold_r = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_act = 0;
      m_hold_n = 0;
      m_hold_r = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1;
        m_c = 0;
        m_w = int'(w_in);
        m_nf = tri_n(m_w);
      end
    end else begin
      m_c++;
      if (m_c > m_nf + 1) begin
        m_act = 0;
        m_hold_n = m_nf;
        m_hold_r = m_w - tri_sum(m_nf);
      end
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      int k;
      if (m_act) begin
        k = (m_c < m_nf) ? m_c : m_nf;
        check("mdl_busy", int'(busy), 1);
        check("mdl_done", int'(done), (m_c == m_nf + 1) ? 1 : 0);
        check("mdl_n", int'(n), k);
        check("mdl_rem", int'(rem), m_w - tri_sum(k));
      end else begin
        check("mdl_busy", int'(busy), 0);
        check("mdl_done", int'(done), 0);
        check("mdl_n", int'(n), m_hold_n);
        check("mdl_rem", int'(rem), m_hold_r);
      end
    end
  end

  int cyc;
  int got_n;
  int got_r;

  // Counts busy cycles from now until done (inclusive).
  task automatic wait_done(input int limit);
    bit seen = 0;
    cyc = 0;
    for (int i = 0; i < limit; i++) begin
      if (busy) cyc++;
      if (done) begin
        seen = 1;
        got_n = int'(n);
        got_r = int'(rem);
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic kick(input int w);
    @(negedge clk);
    start = 1'b1;
    w_in = WIDTH'(w);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input string tag, input int w,
                     input int en, input int er, input int eb);
    kick(w);
    wait_done(100);
    check({tag, "_n"}, got_n, en);
    check({tag, "_rem"}, got_r, er);
    check({tag, "_busy_cycles"}, cyc, eb);
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    bit dseen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_n", int'(n), 0);
    check("rst_rem", int'(rem), 0);

    run("w45", 45, 9, 0, 11);
    run("w63", 63, 10, 8, 12);
    repeat (3) @(negedge clk);
    check("hold_n", int'(n), 10);
    check("hold_rem", int'(rem), 8);
    run("w0", 0, 0, 0, 2);
    run("w1", 1, 1, 0, 3);
    run("w2", 2, 1, 1, 3);

    kick(20);
    @(negedge clk);
    start = 1'b1;
    w_in = WIDTH'(3);
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    check("ign_n", got_n, 5);
    check("ign_rem", got_r, 5);
    @(negedge clk);

    kick(55);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_n", int'(n), 0);
    check("abort_rem", int'(rem), 0);
    dseen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dseen = 1;
    end
    check("abort_no_done", int'(dseen), 0);
    run("w10", 10, 4, 0, 6);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tri_decoder.md
TRI_DECODER -- requirements
Module: tri_decoder

Interface
REQ-001 Parameter WIDTH, default 6: width of the input value and the remainder.
REQ-002 Parameter CNT_W, default 4: width of the term counter; it SHALL be large enough to hold WIDTH-bit max n + 1 (4 for WIDTH=6).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to decode w_in; sampled only in IDLE.
REQ-006 w_in  input  WIDTH  value to decompose; sampled on the accepted start.
REQ-007 busy  output  1  high while a decode is in progress (SUB or DONE).
REQ-008 done  output  1  one-cycle pulse; n and rem are valid.
REQ-009 n  output  CNT_W  number of terms removed: largest n with 1+2+...+n <= w_in.
REQ-010 rem  output  WIDTH  w_in minus (1+2+...+n).

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SUB, DONE.
REQ-012 IDLE with start=1: the block SHALL load r<=w_in, b<=1, n<=0, and go to SUB; start=0 keeps IDLE with all registers holding.
REQ-013 SUB with r >= b: the block SHALL set r<=r-b, n<=n+1, b<=b+1, and stay in SUB.
REQ-014 SUB with r < b: the block SHALL leave r, n and b unchanged and go to DONE.
REQ-015 DONE: the block SHALL assert done for exactly that one cycle and go to IDLE unconditionally.
REQ-016 rem SHALL be driven directly from r, and n from the term counter (registered outputs, no combinational path from inputs).
REQ-017 busy SHALL be 1 in SUB and DONE, and 0 in IDLE.
REQ-018 Latency: with start sampled at edge E0, SUB SHALL last n+1 cycles, and done SHALL be high in the cycle after edge E0+n+1.
REQ-019 start while in SUB or DONE SHALL be ignored, with no queuing and no effect on the result.
REQ-020 n and rem SHALL hold their final values after done until the next accepted start.
REQ-021 The compare r >= b SHALL be unsigned, with b zero-extended to WIDTH; r SHALL never underflow.
REQ-022 b SHALL be CNT_W bits wide and SHALL never wrap for any WIDTH-bit input (max b = n+1).
REQ-023 w_in=0 SHALL give one SUB cycle, done with n=0 and rem=0.
REQ-024 The block SHALL be the inverse of the accumulate-1-to-k sequence: feeding w_in = k(k+1)/2 SHALL return n=k, rem=0.

Reset
REQ-025 While reset=1 at a clock edge, the block SHALL go to state IDLE and set r=0, b=0, n=0, busy=0, done=0; rem SHALL read 0.
REQ-026 Reset SHALL take priority over start and over any in-progress state, including mid-SUB and DONE; the aborted decode SHALL produce no done pulse.
REQ-027 On the first edge with reset=0, the block SHALL be in IDLE and able to accept start.

Verification
REQ-028 Bench: reset 2 cycles -> busy=0, done=0, n=0, rem=0.
REQ-029 Bench: start with w_in=45 -> 10 SUB cycles, then done=1 for one cycle with n=9, rem=0.
REQ-030 Bench: start with w_in=63 -> done with n=10, rem=8; busy high for 12 cycles total.
REQ-031 Bench: start with w_in=0 -> done with n=0, rem=0 in the cycle after edge E0+1.
REQ-032 Bench: w_in=20 started, then start pulsed with w_in=3 during SUB -> second start ignored; done with n=5, rem=5.
REQ-033 Bench: w_in=55 started, reset asserted at the 4th SUB cycle -> IDLE with outputs 0 and no done pulse; a new start with w_in=10 -> n=4, rem=0.
